// File: rtl/calendar_date.sv
// BCD date counter (2000-2099, leap-aware) driven by the clock block's end-of-day carry.
// It has up/set editing and an eight-digit active-low 7-segment YYYYMMDD display.
module calendar_date (
  input  logic        clock,
  input  logic        reset,
  input  logic        day_carry,
  input  logic [2:0]  up,
  input  logic        set,
  output logic        year_carry,
  output logic [55:0] date_7seg
);

  logic [7:0] day_q, day_d;
  logic [7:0] month_q, month_d;
  logic [7:0] year_q, year_d;
  logic [2:0] up_q;
  logic       carry_q, carry_d;
  logic [2:0] rise;
  logic [7:0] max_q, max_new;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic is_leap(input logic [7:0] y);
    logic [3:0] o;
    o = y[3:0];
    if (!y[4]) return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
    else       return (o == 4'd2) || (o == 4'd6);
  endfunction

  function automatic logic [7:0] month_max(input logic [7:0] m, input logic lp);
    case (m)
      8'h02:                      return lp ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign rise    = up & ~up_q;
  assign max_q   = month_max(month_q, is_leap(year_q));

  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    carry_d = 1'b0;
    max_new = max_q;
    if (set) begin
      // One field per cycle: year beats month beats day.
      if (rise[2]) begin
        year_d = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
        if (month_q == 8'h02 && day_q == 8'h29 && !is_leap(year_d)) day_d = 8'h28;
      end else if (rise[1]) begin
        month_d = (month_q == 8'h12) ? 8'h01 : bcd_inc(month_q);
        max_new = month_max(month_d, is_leap(year_q));
        // Packed BCD orders the same as binary, so a plain compare clamps correctly.
        if (day_q > max_new) day_d = max_new;
      end else if (rise[0]) begin
        day_d = (day_q == max_q) ? 8'h01 : bcd_inc(day_q);
      end
    end else if (day_carry) begin
      if (day_q == max_q) begin
        day_d = 8'h01;
        if (month_q == 8'h12) begin
          month_d = 8'h01;
          if (year_q == 8'h99) begin
            year_d  = 8'h00;
            carry_d = 1'b1;
          end else begin
            year_d = bcd_inc(year_q);
          end
        end else begin
          month_d = bcd_inc(month_q);
        end
      end else begin
        day_d = bcd_inc(day_q);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      day_q   <= 8'h01;
      month_q <= 8'h01;
      year_q  <= 8'h00;
      up_q    <= 3'b111;
      carry_q <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      up_q    <= up;
      carry_q <= carry_d;
    end
  end

  assign year_carry = carry_q;
  assign date_7seg  = {seg(4'd2), seg(4'd0), seg(year_q[7:4]), seg(year_q[3:0]),
                       seg(month_q[7:4]), seg(month_q[3:0]), seg(day_q[7:4]), seg(day_q[3:0])};

endmodule

// File: tb/tb_calendar_date.sv
// Directed bench for calendar_date: set-mode loading, run-mode rollovers, century carry,
// button edge rules and asynchronous reset.
module tb_calendar_date;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        day_carry = 1'b0;
  logic [2:0]  up = 3'b000;
  logic        set = 1'b0;
  logic        year_carry;
  logic [55:0] date_7seg;

  int n_checks = 0;
  int n_pass = 0;

  calendar_date dut (
    .clock     (clock),
    .reset     (reset),
    .day_carry (day_carry),
    .up        (up),
    .set       (set),
    .year_carry(year_carry),
    .date_7seg (date_7seg)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [55:0] exp_seg(input int y, input int m, input int d);
    return {pat(2), pat(0), pat((y % 100) / 10), pat(y % 10),
            pat(m / 10), pat(m % 10), pat(d / 10), pat(d % 10)};
  endfunction

  task automatic check(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press(input int idx);
    @(negedge clock);
    up[idx] = 1'b1;
    @(negedge clock);
    up[idx] = 1'b0;
  endtask

  task automatic pulse_carry();
    @(negedge clock);
    day_carry = 1'b1;
    @(negedge clock);
    day_carry = 1'b0;
  endtask

  // From reset, reach the given date by button presses in set mode.
  task automatic load(input int y, input int m, input int d);
    up  = 3'b000;
    set = 1'b1;
    do_reset();
    for (int i = 0; i < y - 2000; i++) press(2);
    for (int i = 1; i < m; i++) press(1);
    for (int i = 1; i < d; i++) press(0);
  endtask

  initial begin
    // Reset with day button held: no increment until it is released and pressed again.
    set = 1'b1;
    up  = 3'b001;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_date", date_7seg, exp_seg(2000, 1, 1));
    check("reset_carry", {55'd0, year_carry}, 56'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("held_through_reset", date_7seg, exp_seg(2000, 1, 1));
    up = 3'b000;
    @(negedge clock);
    check("release_no_change", date_7seg, exp_seg(2000, 1, 1));
    up = 3'b001;
    repeat (4) @(negedge clock);
    check("repress_one_inc", date_7seg, exp_seg(2000, 1, 2));
    up = 3'b000;

    // Leap February in run mode.
    load(2000, 2, 28);
    check("load_2000_02_28", date_7seg, exp_seg(2000, 2, 28));
    set = 1'b0;
    pulse_carry();
    check("run_2000_02_29", date_7seg, exp_seg(2000, 2, 29));
    pulse_carry();
    check("run_2000_03_01", date_7seg, exp_seg(2000, 3, 1));

    load(2001, 2, 28);
    set = 1'b0;
    pulse_carry();
    check("run_2001_03_01", date_7seg, exp_seg(2001, 3, 1));

    load(2000, 4, 30);
    set = 1'b0;
    pulse_carry();
    check("run_30day_month", date_7seg, exp_seg(2000, 5, 1));

    // Century rollover and one-cycle carry.
    load(2099, 12, 31);
    check("load_2099_12_31", date_7seg, exp_seg(2099, 12, 31));
    set = 1'b0;
    pulse_carry();
    check("century_date", date_7seg, exp_seg(2000, 1, 1));
    check("century_carry_hi", {55'd0, year_carry}, 56'd1);
    @(negedge clock);
    check("century_carry_lo", {55'd0, year_carry}, 56'd0);
    check("century_date_hold", date_7seg, exp_seg(2000, 1, 1));

    // Set-mode clamping and day wrap without month carry.
    load(2000, 1, 31);
    press(1);
    check("month_clamp_leap", date_7seg, exp_seg(2000, 2, 29));
    press(2);
    check("year_clamp_0229", date_7seg, exp_seg(2001, 2, 28));
    check("set_no_carry", {55'd0, year_carry}, 56'd0);
    press(0);
    check("day_wrap_01", date_7seg, exp_seg(2001, 2, 1));
    for (int i = 0; i < 27; i++) press(0);
    check("day_28_presses", date_7seg, exp_seg(2001, 2, 28));

    load(2000, 12, 15);
    press(1);
    check("month_wrap_12", date_7seg, exp_seg(2000, 1, 15));

    // day_carry ignored in set mode; year has priority over day.
    load(2000, 4, 30);
    pulse_carry();
    pulse_carry();
    check("set_drops_carry", date_7seg, exp_seg(2000, 4, 30));
    @(negedge clock);
    up = 3'b101;
    @(negedge clock);
    up = 3'b000;
    check("year_beats_day", date_7seg, exp_seg(2001, 4, 30));

    // Asynchronous reset between edges.
    load(2057, 9, 15);
    set = 1'b0;
    pulse_carry();
    check("run_2057_09_16", date_7seg, exp_seg(2057, 9, 16));
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_date", date_7seg, exp_seg(2000, 1, 1));
    check("async_reset_carry", {55'd0, year_carry}, 56'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
